// File: rtl/user_io_pkg.sv
// Shared constants, register map and helpers for the user IO controller.
package user_io_pkg;

  localparam int NUM_IO = 38;
  localparam int HI_W   = NUM_IO - 32;

  localparam logic [5:0] OFF_OUT_LO  = 6'h00;
  localparam logic [5:0] OFF_OUT_HI  = 6'h01;
  localparam logic [5:0] OFF_OEB_LO  = 6'h02;
  localparam logic [5:0] OFF_OEB_HI  = 6'h03;
  localparam logic [5:0] OFF_IN_LO   = 6'h04;
  localparam logic [5:0] OFF_IN_HI   = 6'h05;
  localparam logic [5:0] OFF_IEN_LO  = 6'h06;
  localparam logic [5:0] OFF_IEN_HI  = 6'h07;
  localparam logic [5:0] OFF_POL_LO  = 6'h08;
  localparam logic [5:0] OFF_POL_HI  = 6'h09;
  localparam logic [5:0] OFF_STAT_LO = 6'h0A;
  localparam logic [5:0] OFF_STAT_HI = 6'h0B;

  localparam logic [NUM_IO-1:0] OUT_RST = '0;
  localparam logic [NUM_IO-1:0] OEB_RST = '1;

  typedef enum logic {ST_IDLE, ST_ACK} state_e;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Byte-masked merge of a bus word into the LO or HI slice of a pad vector.
  function automatic logic [NUM_IO-1:0] merge_word(input logic [NUM_IO-1:0] old,
                                                   input logic hit_lo, input logic hit_hi,
                                                   input logic [31:0] val, input logic [31:0] mask);
    logic [NUM_IO-1:0] res;
    res = old;
    if (hit_lo) res[31:0] = (old[31:0] & ~mask) | (val & mask);
    if (hit_hi) res[NUM_IO-1:32] = (old[NUM_IO-1:32] & ~mask[HI_W-1:0]) |
                                   (val[HI_W-1:0] & mask[HI_W-1:0]);
    return res;
  endfunction

  function automatic logic [31:0] hi_word(input logic [NUM_IO-1:0] vec);
    return {{(32-HI_W){1'b0}}, vec[NUM_IO-1:32]};
  endfunction

endpackage

// File: rtl/user_io_sync_edge.sv
// Two-flop pad synchronizer plus polarity-qualified edge detector.
// With USER_IO_DEBOUNCE_EN defined, a tick-sampled filter sits before the edge detector.
module user_io_sync_edge
  import user_io_pkg::*;
#(
  parameter int WIDTH        = NUM_IO,
  parameter int DEBOUNCE_DIV = 1000
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] pol_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] level;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

`ifdef USER_IO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick;
  logic [WIDTH-1:0] sample_q;
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] stable;

  assign tick   = (cnt_q == CNT_MAX);
  assign stable = ~(sync_q ^ sample_q);

  // A filtered bit follows the input only when two consecutive ticks agree.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q    <= '0;
      sample_q <= '0;
      filt_q   <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        sample_q <= sync_q;
        filt_q   <= (sync_q & stable) | (filt_q & ~stable);
      end
    end
  end

  assign level = filt_q;
`else
  localparam int unused_debounce_div = DEBOUNCE_DIV;
  assign level = sync_q;
`endif

  always_ff @(posedge clk_i) begin
    if (srst_i) prev_q <= '0;
    else        prev_q <= level;
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign edge_o[gi] = pol_i[gi] ? (prev_q[gi] & ~level[gi])
                                    : (level[gi] & ~prev_q[gi]);
    end
  endgenerate

  assign sync_o = level;

endmodule

// File: rtl/user_io_ctrl.sv
// Wishbone register front-end for the user IO pads and user interrupts.
// Optional input debounce is enabled by defining USER_IO_DEBOUNCE_EN.
module user_io_ctrl
  import user_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          DEBOUNCE_DIV = 1000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic [2:0]        irq
);

  state_e state_q, state_d;

  logic [NUM_IO-1:0] out_q, out_d;
  logic [NUM_IO-1:0] oeb_q, oeb_d;
  logic [NUM_IO-1:0] ien_q, ien_d;
  logic [NUM_IO-1:0] pol_q, pol_d;
  logic [NUM_IO-1:0] stat_q, stat_d;
  logic [NUM_IO-1:0] stat_clr;
  logic [31:0]       dat_q, dat_d;
  logic [2:0]        irq_q, irq_d;

  logic [NUM_IO-1:0] pad_sync;
  logic [NUM_IO-1:0] pad_edge;
  logic [31:0]       wmask;
  logic [31:0]       rdata;
  logic [5:0]        word;
  logic              in_window;
  logic              accept;
  logic              wr;
  logic              unused_adr;

  assign in_window  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign accept     = (state_q == ST_IDLE) && wbs_cyc_i && wbs_stb_i && in_window;
  assign wr         = accept && wbs_we_i;
  assign word       = wbs_adr_i[7:2];
  assign wmask      = sel_mask(wbs_sel_i);
  assign unused_adr = ^wbs_adr_i[1:0];

  user_io_sync_edge #(
    .WIDTH        (NUM_IO),
    .DEBOUNCE_DIV (DEBOUNCE_DIV)
  ) u_sync_edge (
    .clk_i  (wb_clk_i),
    .srst_i (wb_rst_i),
    .d_i    (io_in),
    .pol_i  (pol_q),
    .sync_o (pad_sync),
    .edge_o (pad_edge)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (word)
      OFF_OUT_LO:  rdata = out_q[31:0];
      OFF_OUT_HI:  rdata = hi_word(out_q);
      OFF_OEB_LO:  rdata = oeb_q[31:0];
      OFF_OEB_HI:  rdata = hi_word(oeb_q);
      OFF_IN_LO:   rdata = pad_sync[31:0];
      OFF_IN_HI:   rdata = hi_word(pad_sync);
      OFF_IEN_LO:  rdata = ien_q[31:0];
      OFF_IEN_HI:  rdata = hi_word(ien_q);
      OFF_POL_LO:  rdata = pol_q[31:0];
      OFF_POL_HI:  rdata = hi_word(pol_q);
      OFF_STAT_LO: rdata = stat_q[31:0];
      OFF_STAT_HI: rdata = hi_word(stat_q);
      default:     rdata = '0;
    endcase
  end

  // New edges are OR-ed in after the clear so a coincident event survives a W1C.
  always_comb begin
    out_d    = merge_word(out_q, wr && word == OFF_OUT_LO, wr && word == OFF_OUT_HI, wbs_dat_i, wmask);
    oeb_d    = merge_word(oeb_q, wr && word == OFF_OEB_LO, wr && word == OFF_OEB_HI, wbs_dat_i, wmask);
    ien_d    = merge_word(ien_q, wr && word == OFF_IEN_LO, wr && word == OFF_IEN_HI, wbs_dat_i, wmask);
    pol_d    = merge_word(pol_q, wr && word == OFF_POL_LO, wr && word == OFF_POL_HI, wbs_dat_i, wmask);
    stat_clr = merge_word('0, wr && word == OFF_STAT_LO, wr && word == OFF_STAT_HI, wbs_dat_i, wmask);
    stat_d   = (stat_q & ~stat_clr) | pad_edge;
    dat_d    = (accept && !wbs_we_i) ? rdata : '0;
    irq_d    = {1'b0, |(stat_q[NUM_IO-1:32] & ien_q[NUM_IO-1:32]), |(stat_q[31:0] & ien_q[31:0])};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      out_q   <= OUT_RST;
      oeb_q   <= OEB_RST;
      ien_q   <= '0;
      pol_q   <= '0;
      stat_q  <= '0;
      dat_q   <= '0;
      irq_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      ien_q   <= ien_d;
      pol_q   <= pol_d;
      stat_q  <= stat_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
    end
  end

  assign wbs_ack_o = (state_q == ST_ACK);
  assign wbs_dat_o = dat_q;
  assign io_out    = out_q;
  assign io_oeb    = oeb_q;
  assign irq       = irq_q;

endmodule

// File: doc/user_io_ctrl.md
# user_io_ctrl

Wishbone-configured controller for the 38 user IO pads and the 3 user interrupt lines of the user project area. Sits between the management Wishbone slave port and the pad signals (`io_in`/`io_out`/`io_oeb`), replacing direct tie-offs. It holds output and output-enable registers, synchronizes pad inputs, detects configurable edges and raises `irq`. Single clock domain.

## Interface
- `NUM_IO`, 38, pad count; fixed by the padframe.
- `BASE_ADDR`, 32'h3000_0000, window base; decode compares `wbs_adr_i[31:8]` against `BASE_ADDR[31:8]`.
- `DEBOUNCE_DIV`, 1000, debounce tick period in clocks; used only with the debounce macro.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  synchronous active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic cycle, strobe and write enable.
- `wbs_sel_i`  in  4  byte lanes.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  registered acknowledge.
- `wbs_dat_o`  out  32  read data; 0 when ack is low.
- `io_in`  in  38  pad inputs, asynchronous.
- `io_out`  out  38  pad output values.
- `io_oeb`  out  38  pad output-enable, active low.
- `irq`  out  3  user interrupts.

## Operation
- Register map. Offsets are `adr[7:2]`. HI words use bits [5:0]; upper bits read 0.
  - 0x00/0x04 `OUT`: RW, reset 0.
  - 0x08/0x0C `OEB`: RW, reset all 1 (all pads are inputs).
  - 0x10/0x14 `IN`: RO, synchronized pad state.
  - 0x18/0x1C `IEN`: RW, reset 0.
  - 0x20/0x24 `POL`: RW, reset 0. 0 = rising edge, 1 = falling edge.
  - 0x28/0x2C `STAT`: W1C, reset 0.
- Access FSM has two states, IDLE and ACK.
  - IDLE → ACK when `cyc&stb` and the address is in the window. The write commits on this edge.
  - ACK → IDLE unconditionally. Ack is high for exactly one cycle, and there is at least one idle cycle between acks.
- Byte enables: `wbs_sel_i` masks writes per byte on RW and W1C registers. Reads ignore `sel`.
- Unmapped offsets inside the window are acked; they read 0 and writes are dropped.
- Addresses outside the window are never acked.
- Input path: two-flop synchronizer per pad. Edge = synchronized value versus its previous value, qualified per bit by `POL`. An edge sets the `STAT` bit regardless of `IEN`.
- Interrupts, all registered:
  - `irq[0]` = |(STAT_LO & IEN_LO).
  - `irq[1]` = |(STAT_HI & IEN_HI).
  - `irq[2]` = 0.
- Simultaneous events: an edge and a W1C on the same bit in the same cycle leave the bit at 1 (the event wins).
- Reset asserted mid-transaction: ack drops on the next edge, all registers take their reset values, and the FSM goes to IDLE. The master must retry.
- `io_out` and `io_oeb` are driven directly from the registers.

## Timing
- Write: request seen at edge k. Register and pad outputs are updated at k+1, and `wbs_ack_o` is high during cycle k+1.
- Read: data is registered and presented together with the ack at k+1.
- Pad change sampled at edge k:
  - `IN` reflects it at k+1.
  - `STAT` is set at k+2.
  - `irq` asserts at k+3.
- All outputs are 0 out of reset except `io_oeb`, which is all 1.

## Configuration
- `USER_IO_DEBOUNCE_EN` defined:
  - A shared counter produces a tick every `DEBOUNCE_DIV` clocks.
  - Each synchronized bit feeds a filtered value that changes only when two consecutive ticks sample the same new level.
  - `IN` and edge detection use the filtered value, which adds latency of up to 2×`DEBOUNCE_DIV`+1 cycles.
  - The counter resets to 0.
- Macro undefined: no counter. Edge detection and `IN` use the synchronizer output directly, with the latency given in Timing.

## Structure
- Package `user_io_pkg` holds:
  - `NUM_IO`;
  - the register offset localparams;
  - the reset values of `OUT` and `OEB`;
  - the FSM state enum (`ST_IDLE`, `ST_ACK`).
- Sub-module `user_io_sync_edge`: per-vector synchronizer, optional debounce and polarity-qualified edge detector. Outputs are `sync[37:0]` and `edge[37:0]`.
- The top module keeps address decode, the FSM, the register file and irq generation.

## Test plan
- Reset, then read 0x08 and 0x0C: 32'hFFFF_FFFF and 32'h0000_003F; `io_oeb` is all 1 and ack lasts one cycle.
- Write 0x00 = 32'hA5A5_A5A5 with sel=4'b0011: `io_out[31:0]` = 32'h0000_A5A5 one cycle later, and readback matches.
- Set IEN_LO bit 3 and POL=0, then drive `io_in[3]` 0→1: STAT_LO=32'h8 at k+2, `irq[0]`=1 at k+3. Write STAT_LO=32'h8: `irq[0]` drops.
- Set POL_HI bit 5 = 1 and drive `io_in[37]` 1→0: STAT_HI=6'h20. Issue a W1C in the same cycle as a second edge: the bit stays 1.
- Access 0x3000_0100 (outside the window): no ack within 16 cycles. Read 0x3000_0040 (unmapped): ack with data 0.
- Assert `wb_rst_i` during an ack cycle: ack is 0 next cycle and all registers are back at reset values. With `USER_IO_DEBOUNCE_EN` and `DEBOUNCE_DIV`=4, a 3-cycle glitch on `io_in[0]` never sets STAT.
